// File: rtl/crank_decoder_pkg.sv
// Shared crank-wheel definitions for the crank decoder and the injector and
// ignition drivers that consume its phase output.
//   crank_state_t     : decoder state encoding
//   DEF_*             : default wheel and timing constants
//   gap_detect()      : missing-tooth test on two consecutive tooth periods
package crank_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_SYNCED = 2'd2
  } crank_state_t;

  localparam int          DEF_TEETH_TOTAL   = 36;
  localparam int          DEF_TEETH_MISSING = 1;
  localparam int          DEF_FILTER_CYCLES = 8;
  localparam logic [31:0] DEF_STALL_CYCLES  = 32'd50_000_000;

  // True when cur exceeds 1.5x prev. Both sides are widened to 34 bits so
  // that 3*prev cannot overflow for any 32-bit period.
  function automatic logic gap_detect(input logic [31:0] cur, input logic [31:0] prev);
    logic [33:0] lhs;
    logic [33:0] rhs;
    lhs = {1'b0, cur, 1'b0};
    rhs = {2'b00, prev} + {1'b0, prev, 1'b0};
    return lhs > rhs;
  endfunction

endpackage

// File: rtl/input_filter.sv
// Two-flop synchronizer followed by a level filter. A new input level is
// accepted only after it has been seen on the synchronized input for
// FILTER_CYCLES consecutive clocks; shorter pulses and dropouts are ignored.
// Used for the crank input and intended for the cam input as well.
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   raw      in   asynchronous sensor input
//   level    out  filtered, synchronous level
module input_filter
  import crank_decoder_pkg::*;
#(
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  localparam int            CW   = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  logic          sync_ff1;
  logic          sync_ff2;
  logic [CW-1:0] hold_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff1 <= 1'b0;
      sync_ff2 <= 1'b0;
      hold_cnt <= '0;
      level    <= 1'b0;
    end else begin
      sync_ff1 <= raw;
      sync_ff2 <= sync_ff1;
      // Any return to the accepted level restarts the qualification window.
      if (sync_ff2 == level) begin
        hold_cnt <= '0;
      end else if (hold_cnt == LAST) begin
        level    <= sync_ff2;
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/crank_decoder.sv
// Missing-tooth crank wheel decoder. Filters the crank sensor, measures the
// period between teeth, locks onto the sync gap and then emits one trigger
// per tooth with the tooth index within the revolution.
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   crank_in       in   raw crank sensor, tooth = rising edge
//   trigger        out  one-cycle pulse per accepted tooth while synced
//   eng_phase      out  tooth index, valid with trigger
//   synced         out  high while locked to the wheel
//   tooth_period   out  clk cycles between the last two accepted teeth
//   sync_loss_cnt  out  saturating count of lost lock events
//
// state     | meaning
// ST_IDLE   | engine stopped or just reset, waiting for any tooth
// ST_HUNT   | teeth arriving, looking for the sync gap
// ST_SYNCED | locked, tooth index tracks the wheel
module crank_decoder
  import crank_decoder_pkg::*;
#(
  parameter int          TEETH_TOTAL   = DEF_TEETH_TOTAL,
  parameter int          TEETH_MISSING = DEF_TEETH_MISSING,
  parameter int          FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter logic [31:0] STALL_CYCLES  = DEF_STALL_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        crank_in,
  output logic        trigger,
  output logic [15:0] eng_phase,
  output logic        synced,
  output logic [31:0] tooth_period,
  output logic [7:0]  sync_loss_cnt
);

  localparam logic [15:0] GAP_IDX = 16'(TEETH_TOTAL - TEETH_MISSING - 1);

  crank_state_t state;
  logic         level;
  logic         level_q;
  logic         tooth_evt;
  logic [31:0]  period_cnt;
  logic [31:0]  prev_period;
  logic         prev_valid;
  logic [15:0]  tooth_idx;
  logic         stall;
  logic         gap;
  logic         gap_expected;

  input_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_crank_filter (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (crank_in),
    .level  (level)
  );

  assign tooth_evt    = level & ~level_q;
  // Equality rather than >= so the stall fires once; the counter runs on
  // past it, letting the next tooth leave IDLE normally.
  assign stall        = (period_cnt == STALL_CYCLES);
  assign gap          = prev_valid & gap_detect(period_cnt, prev_period);
  assign gap_expected = (tooth_idx == GAP_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      level_q       <= 1'b0;
      period_cnt    <= '0;
      prev_period   <= '0;
      prev_valid    <= 1'b0;
      tooth_idx     <= '0;
      trigger       <= 1'b0;
      eng_phase     <= '0;
      synced        <= 1'b0;
      tooth_period  <= '0;
      sync_loss_cnt <= '0;
    end else begin
      level_q <= level;
      trigger <= 1'b0;

      if (tooth_evt) begin
        period_cnt <= 32'd1;
      end else if (period_cnt != '1) begin
        period_cnt <= period_cnt + 32'd1;
      end

      if (stall) begin
        state      <= ST_IDLE;
        synced     <= 1'b0;
        prev_valid <= 1'b0;
      end else if (tooth_evt) begin
        tooth_period <= period_cnt;
        prev_period  <= period_cnt;
        case (state)
          ST_IDLE: begin
            // Period since IDLE is meaningless, so it cannot serve as prev.
            state      <= ST_HUNT;
            prev_valid <= 1'b0;
          end
          ST_HUNT: begin
            prev_valid <= 1'b1;
            if (gap) begin
              state     <= ST_SYNCED;
              synced    <= 1'b1;
              tooth_idx <= '0;
              trigger   <= 1'b1;
              eng_phase <= '0;
            end
          end
          ST_SYNCED: begin
            prev_valid <= 1'b1;
            if (gap == gap_expected) begin
              trigger <= 1'b1;
              if (gap) begin
                tooth_idx <= '0;
                eng_phase <= '0;
              end else begin
                tooth_idx <= tooth_idx + 16'd1;
                eng_phase <= tooth_idx + 16'd1;
              end
            end else begin
              state  <= ST_HUNT;
              synced <= 1'b0;
              if (sync_loss_cnt != 8'hFF) begin
                sync_loss_cnt <= sync_loss_cnt + 8'd1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
